// File: rtl/ibex_rf_wport_arbiter.sv
// Write-port owner for the latch-based register file: zero-init sweep after reset,
// EX/LSU writeback arbitration with EX starvation guard, and a one-cycle forwarding record.
module ibex_rf_wport_arbiter #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter bit                   InitOnReset = 1'b1,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  parameter int unsigned          MaxStall    = 2
) (
  input  logic                 clk_int,
  input  logic                 rst_ni,
  input  logic                 ex_req_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_gnt_o,
  input  logic                 lsu_req_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_gnt_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 init_busy_o,
  output logic                 fwd_valid_o,
  output logic [4:0]           fwd_addr_o,
  output logic [DataWidth-1:0] fwd_data_o
);

  localparam int unsigned NumWords = RV32E ? 16 : 32;
  localparam logic [4:0]  LastWord = 5'(NumWords - 1);
  localparam logic [2:0]  StallMax = 3'(MaxStall);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam state_e ResetState = InitOnReset ? ST_INIT : ST_RUN;

  state_e               state_q, state_d;
  logic [4:0]           sweep_q, sweep_d;
  logic [2:0]           stall_q, stall_d;
  logic                 ex_win, lsu_win, we;
  logic [4:0]           sel_addr;
  logic [DataWidth-1:0] sel_data;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d  = state_q;
    sweep_d  = sweep_q;
    stall_d  = stall_q;
    ex_win   = 1'b0;
    lsu_win  = 1'b0;
    we       = 1'b0;
    sel_addr = '0;
    sel_data = '0;

    unique case (state_q)
      ST_INIT: begin
        we       = 1'b1;
        sel_addr = sweep_q;
        sel_data = WordZeroVal;
        sweep_d  = sweep_q + 5'd1;
        if (sweep_q == LastWord) state_d = ST_RUN;
      end
      ST_RUN: begin
        // LSU has priority unless EX has already been denied MaxStall times in a row.
        if (ex_req_i && (!lsu_req_i || stall_q == StallMax)) ex_win  = 1'b1;
        else if (lsu_req_i)                                  lsu_win = 1'b1;

        if (ex_win) begin
          sel_addr = ex_waddr_i;
          sel_data = ex_wdata_i;
        end else if (lsu_win) begin
          sel_addr = lsu_waddr_i;
          sel_data = lsu_wdata_i;
        end

        // x0 writes are consumed without touching the RF.
        we = (ex_win || lsu_win) && (sel_addr != 5'd0);

        if (ex_req_i && !ex_win) stall_d = (stall_q == StallMax) ? stall_q : stall_q + 3'd1;
        else                     stall_d = '0;
      end
      default: state_d = ResetState;
    endcase
  end

  // NOTE: state resets asynchronously, so outputs are also gated combinationally to be quiet while rst_ni is low.
  assign ex_gnt_o    = rst_ni & ex_win;
  assign lsu_gnt_o   = rst_ni & lsu_win;
  assign rf_we_o     = rst_ni & we;
  assign rf_waddr_o  = rst_ni ? sel_addr : '0;
  assign rf_wdata_o  = rst_ni ? sel_data : '0;
  assign init_busy_o = (state_q == ST_INIT);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ResetState;
      sweep_q     <= 5'd1;
      stall_q     <= '0;
      fwd_valid_o <= 1'b0;
      fwd_addr_o  <= '0;
      fwd_data_o  <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      stall_q <= stall_d;
      if (state_q == ST_RUN) begin
        fwd_valid_o <= we;
        if (we) begin
          fwd_addr_o <= sel_addr;
          fwd_data_o <= sel_data;
        end
      end else begin
        fwd_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ibex_rf_wport_arbiter.sv
// Directed bench for ibex_rf_wport_arbiter: init sweep, arbitration table, reset mid-sweep,
// and an RV32E instance with the sweep disabled.
module tb_ibex_rf_wport_arbiter;

  logic        clk_int = 1'b0;
  logic        rst_ni;
  logic        ex_req, lsu_req;
  logic [4:0]  ex_waddr, lsu_waddr;
  logic [31:0] ex_wdata, lsu_wdata;
  logic        ex_gnt, lsu_gnt, rf_we, init_busy, fwd_valid;
  logic [4:0]  rf_waddr, fwd_addr;
  logic [31:0] rf_wdata, fwd_data;

  logic        rst_e;
  logic        ex_req_e, lsu_req_e;
  logic [4:0]  ex_waddr_e, lsu_waddr_e;
  logic [31:0] ex_wdata_e, lsu_wdata_e;
  logic        ex_gnt_e, lsu_gnt_e, rf_we_e, init_busy_e, fwd_valid_e;
  logic [4:0]  rf_waddr_e, fwd_addr_e;
  logic [31:0] rf_wdata_e, fwd_data_e;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_int = ~clk_int;

  ibex_rf_wport_arbiter dut (
    .clk_int(clk_int), .rst_ni(rst_ni),
    .ex_req_i(ex_req), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_gnt_o(ex_gnt),
    .lsu_req_i(lsu_req), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata), .lsu_gnt_o(lsu_gnt),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .init_busy_o(init_busy),
    .fwd_valid_o(fwd_valid), .fwd_addr_o(fwd_addr), .fwd_data_o(fwd_data)
  );

  ibex_rf_wport_arbiter #(.RV32E(1'b1), .InitOnReset(1'b0)) dut_e (
    .clk_int(clk_int), .rst_ni(rst_e),
    .ex_req_i(ex_req_e), .ex_waddr_i(ex_waddr_e), .ex_wdata_i(ex_wdata_e), .ex_gnt_o(ex_gnt_e),
    .lsu_req_i(lsu_req_e), .lsu_waddr_i(lsu_waddr_e), .lsu_wdata_i(lsu_wdata_e), .lsu_gnt_o(lsu_gnt_e),
    .rf_we_o(rf_we_e), .rf_waddr_o(rf_waddr_e), .rf_wdata_o(rf_wdata_e), .init_busy_o(init_busy_e),
    .fwd_valid_o(fwd_valid_e), .fwd_addr_o(fwd_addr_e), .fwd_data_o(fwd_data_e)
  );

  typedef struct {
    logic        ex_req;
    logic [4:0]  ex_addr;
    logic [31:0] ex_data;
    logic        lsu_req;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        ex_gnt;
    logic        lsu_gnt;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        fv;
    logic [4:0]  fa;
    logic [31:0] fd;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_int);
    #1;
  endtask

  initial begin
    // ex_req ex_addr ex_data | lsu_req lsu_addr lsu_data | ex_gnt lsu_gnt we waddr wdata | fv fa fd
    tbl[0]  = '{0, 0,  0,            0, 0,  0,            0, 0, 0, 0,  0,            1, 5,  32'hDEADBEEF};
    tbl[1]  = '{0, 0,  0,            0, 0,  0,            0, 0, 0, 0,  0,            0, 0,  0};
    tbl[2]  = '{0, 0,  0,            1, 7,  32'h11111111, 0, 1, 1, 7,  32'h11111111, 0, 0,  0};
    tbl[3]  = '{1, 3,  32'hAAAA0003, 1, 9,  32'h22222222, 0, 1, 1, 9,  32'h22222222, 1, 7,  32'h11111111};
    tbl[4]  = '{1, 3,  32'hAAAA0003, 1, 10, 32'h33333333, 0, 1, 1, 10, 32'h33333333, 1, 9,  32'h22222222};
    tbl[5]  = '{1, 3,  32'hAAAA0003, 1, 11, 32'h44444444, 1, 0, 1, 3,  32'hAAAA0003, 1, 10, 32'h33333333};
    tbl[6]  = '{1, 4,  32'hAAAA0004, 1, 11, 32'h44444444, 0, 1, 1, 11, 32'h44444444, 1, 3,  32'hAAAA0003};
    tbl[7]  = '{1, 4,  32'hAAAA0004, 1, 12, 32'h55555555, 0, 1, 1, 12, 32'h55555555, 1, 11, 32'h44444444};
    tbl[8]  = '{1, 4,  32'hAAAA0004, 1, 13, 32'h66666666, 1, 0, 1, 4,  32'hAAAA0004, 1, 12, 32'h55555555};
    tbl[9]  = '{1, 0,  32'h12345678, 0, 0,  0,            1, 0, 0, 0,  0,            1, 4,  32'hAAAA0004};
    tbl[10] = '{0, 0,  0,            0, 0,  0,            0, 0, 0, 0,  0,            0, 0,  0};
    tbl[11] = '{1, 6,  32'hBBBB0006, 1, 14, 32'h77770014, 0, 1, 1, 14, 32'h77770014, 0, 0,  0};
    tbl[12] = '{0, 0,  0,            1, 15, 32'h77770015, 0, 1, 1, 15, 32'h77770015, 1, 14, 32'h77770014};
    tbl[13] = '{1, 6,  32'hBBBB0006, 1, 16, 32'h77770016, 0, 1, 1, 16, 32'h77770016, 1, 15, 32'h77770015};
    tbl[14] = '{1, 6,  32'hBBBB0006, 1, 17, 32'h77770017, 0, 1, 1, 17, 32'h77770017, 1, 16, 32'h77770016};
    tbl[15] = '{0, 0,  0,            0, 0,  0,            0, 0, 0, 0,  0,            1, 17, 32'h77770017};
    tbl[16] = '{0, 0,  0,            1, 0,  32'h00000099, 0, 1, 0, 0,  0,            0, 0,  0};
    tbl[17] = '{0, 0,  0,            0, 0,  0,            0, 0, 0, 0,  0,            0, 0,  0};
    tbl[18] = '{0, 0,  0,            1, 20, 32'h0000CAFE, 0, 1, 1, 20, 32'h0000CAFE, 0, 0,  0};

    rst_ni = 1'b0;  rst_e = 1'b0;
    ex_req = 1'b1;  ex_waddr = 5'd5;  ex_wdata = 32'hDEADBEEF;
    lsu_req = 1'b0; lsu_waddr = '0;   lsu_wdata = '0;
    ex_req_e = 1'b0; ex_waddr_e = '0; ex_wdata_e = '0;
    lsu_req_e = 1'b0; lsu_waddr_e = '0; lsu_wdata_e = '0;

    // Reset state
    @(negedge clk_int);
    check("rst ex_gnt", 32'(ex_gnt), 0);
    check("rst rf_we", 32'(rf_we), 0);
    check("rst rf_waddr", 32'(rf_waddr), 0);
    check("rst rf_wdata", rf_wdata, 0);
    check("rst init_busy", 32'(init_busy), 1);
    check("rst fwd_valid", 32'(fwd_valid), 0);
    cyc();
    rst_ni = 1'b1;

    // Sweep: 31 writes of zero to words 1..31, EX held off
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk_int);
      check($sformatf("sweep%0d waddr", i), 32'(rf_waddr), 32'(i));
      check($sformatf("sweep%0d we", i), 32'(rf_we), 1);
      check($sformatf("sweep%0d wdata", i), rf_wdata, 0);
      check($sformatf("sweep%0d busy", i), 32'(init_busy), 1);
      check($sformatf("sweep%0d ex_gnt", i), 32'(ex_gnt), 0);
      check($sformatf("sweep%0d fwd_valid", i), 32'(fwd_valid), 0);
      cyc();
    end
    @(negedge clk_int);
    check("run ex_gnt", 32'(ex_gnt), 1);
    check("run rf_we", 32'(rf_we), 1);
    check("run rf_waddr", 32'(rf_waddr), 5);
    check("run rf_wdata", rf_wdata, 32'hDEADBEEF);
    check("run busy", 32'(init_busy), 0);
    cyc();

    // Arbitration table
    for (int i = 0; i < 19; i++) begin
      ex_req = tbl[i].ex_req;   ex_waddr = tbl[i].ex_addr;   ex_wdata = tbl[i].ex_data;
      lsu_req = tbl[i].lsu_req; lsu_waddr = tbl[i].lsu_addr; lsu_wdata = tbl[i].lsu_data;
      @(negedge clk_int);
      check($sformatf("row%0d ex_gnt", i), 32'(ex_gnt), 32'(tbl[i].ex_gnt));
      check($sformatf("row%0d lsu_gnt", i), 32'(lsu_gnt), 32'(tbl[i].lsu_gnt));
      check($sformatf("row%0d rf_we", i), 32'(rf_we), 32'(tbl[i].we));
      check($sformatf("row%0d fwd_valid", i), 32'(fwd_valid), 32'(tbl[i].fv));
      if (tbl[i].we) begin
        check($sformatf("row%0d rf_waddr", i), 32'(rf_waddr), 32'(tbl[i].waddr));
        check($sformatf("row%0d rf_wdata", i), rf_wdata, tbl[i].wdata);
      end
      if (tbl[i].fv) begin
        check($sformatf("row%0d fwd_addr", i), 32'(fwd_addr), 32'(tbl[i].fa));
        check($sformatf("row%0d fwd_data", i), fwd_data, tbl[i].fd);
      end
      cyc();
    end

    // Reset in RUN with a live forwarding record, then reset again at sweep word 10
    rst_ni = 1'b0;
    ex_req = 1'b0; lsu_req = 1'b1; lsu_waddr = 5'd1; lsu_wdata = 32'h0000F00D;
    @(negedge clk_int);
    check("rst2 fwd_valid", 32'(fwd_valid), 0);
    check("rst2 fwd_addr", 32'(fwd_addr), 0);
    check("rst2 lsu_gnt", 32'(lsu_gnt), 0);
    check("rst2 rf_we", 32'(rf_we), 0);
    check("rst2 busy", 32'(init_busy), 1);
    cyc();
    rst_ni = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_int);
      check($sformatf("part%0d waddr", i), 32'(rf_waddr), 32'(i));
      check($sformatf("part%0d lsu_gnt", i), 32'(lsu_gnt), 0);
      if (i < 10) cyc();
    end
    #1 rst_ni = 1'b0;
    #1;
    check("rst3 rf_we", 32'(rf_we), 0);
    check("rst3 rf_waddr", 32'(rf_waddr), 0);
    check("rst3 rf_wdata", rf_wdata, 0);
    check("rst3 busy", 32'(init_busy), 1);
    cyc();
    rst_ni = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk_int);
      check($sformatf("resweep%0d waddr", i), 32'(rf_waddr), 32'(i));
      check($sformatf("resweep%0d busy", i), 32'(init_busy), 1);
      check($sformatf("resweep%0d lsu_gnt", i), 32'(lsu_gnt), 0);
      cyc();
    end
    @(negedge clk_int);
    check("resweep lsu_gnt", 32'(lsu_gnt), 1);
    check("resweep busy", 32'(init_busy), 0);
    check("resweep rf_waddr", 32'(rf_waddr), 1);
    cyc();
    lsu_req = 1'b0;
    @(negedge clk_int);
    check("resweep fwd_valid", 32'(fwd_valid), 1);
    check("resweep fwd_addr", 32'(fwd_addr), 1);
    check("resweep fwd_data", fwd_data, 32'h0000F00D);
    cyc();

    // RV32E without sweep: LSU granted right after reset, upper address bit passes through
    lsu_req_e = 1'b1; lsu_waddr_e = 5'd18; lsu_wdata_e = 32'h5A5A5A5A;
    @(negedge clk_int);
    check("e rst busy", 32'(init_busy_e), 0);
    check("e rst lsu_gnt", 32'(lsu_gnt_e), 0);
    check("e rst rf_we", 32'(rf_we_e), 0);
    cyc();
    rst_e = 1'b1;
    @(negedge clk_int);
    check("e lsu_gnt", 32'(lsu_gnt_e), 1);
    check("e rf_we", 32'(rf_we_e), 1);
    check("e rf_waddr", 32'(rf_waddr_e), 18);
    check("e rf_wdata", rf_wdata_e, 32'h5A5A5A5A);
    check("e busy", 32'(init_busy_e), 0);
    cyc();
    ex_req_e = 1'b1; ex_waddr_e = 5'd2; ex_wdata_e = 32'h00000002;
    @(negedge clk_int);
    check("e both lsu_gnt", 32'(lsu_gnt_e), 1);
    check("e both ex_gnt", 32'(ex_gnt_e), 0);
    check("e fwd_addr", 32'(fwd_addr_e), 18);
    check("e fwd_valid", 32'(fwd_valid_e), 1);
    check("e busy2", 32'(init_busy_e), 0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
